spi_xfer_ctrl: RTL and testbench

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_pkg.sv | 41 ++++
 rtl/spi_edge_det.sv | 29 ++
 rtl/spi_xfer_ctrl.sv | 176 +++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared definitions for the SPI transfer controller: FSM state
//             encoding, O_SPI_MODE bit positions, default watchdog limit and
//             the chip-select one-hot helper.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

   // Controller FSM states, explicit 3-bit encoding
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_START   = 3'd2,
      ST_WAIT    = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_FINISH  = 3'd5
   } state_t;

   // Field positions inside the O_SPI_MODE control byte
   localparam int MODE_LSB        = 0;
   localparam int START_BIT       = 3;
   localparam int CS_LSB          = 4;
   localparam int CS_BITS         = 4;

   // Watchdog limit in clock cycles when no override is given
   localparam int TIMEOUT_DEFAULT = 1024;

   // One-hot chip-select enable; indexes beyond N_CS or the 4-bit field give 0
   function automatic logic [3:0] cs_onehot(input int unsigned idx, input int unsigned n_cs);
      logic [3:0] oh;
      oh = 4'b0000;
      if ((idx < n_cs) && (idx < 4)) begin
         oh = 4'(32'd1 << idx);
      end
      return oh;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_edge_det.sv
`default_nettype none
// ============================================================================
//  Module   : spi_edge_det
//  Purpose  : Rising-edge detector. 'rise' is high while din is 1 and its
//             previous sample was 0, so a level held high never retriggers.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic din_q;

   // Remember the previous sample of din
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_q <= 1'b0;
      end else begin
         din_q <= din;
      end
   end

   assign rise = din & ~din_q;

endmodule
`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_xfer_ctrl
//  Purpose  : Command-driven SPI transfer sequencer. Accepts a command
//             (length, chip select, mode, divider), streams bytes to an
//             external SPI core one at a time, returns received bytes and
//             signals completion. Holds chip select for the whole burst.
//  Options  : SPI_XFER_TIMEOUT_EN - enables the WAIT-state watchdog that
//             aborts a transfer after TIMEOUT cycles and sets O_ERR.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_xfer_ctrl
   import spi_pkg::*;
#(
   parameter int N       = 8,
   parameter int N_CS    = 4,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                                     I_CLK,
   input  logic                                     I_RST_N,
   input  logic                                     I_CMD_VALID,
   output logic                                     O_CMD_READY,
   input  logic [7:0]                               I_CMD_LEN,
   input  logic [((N_CS > 1) ? $clog2(N_CS) : 1)-1:0] I_CMD_CS,
   input  logic [1:0]                               I_CMD_MODE,
   input  logic [7:0]                               I_CMD_DIV,
   input  logic                                     I_TXB_VALID,
   output logic                                     O_TXB_READY,
   input  logic [N-1:0]                             I_TXB_DATA,
   output logic                                     O_RXB_VALID,
   output logic [N-1:0]                             O_RXB_DATA,
   output logic                                     O_BUSY,
   output logic                                     O_DONE,
   output logic                                     O_ERR,
   output logic [N-1:0]                             O_SPI_TX_DATA,
   input  logic [N-1:0]                             I_SPI_RX_DATA,
   output logic [7:0]                               O_SPI_MODE,
   output logic [7:0]                               O_SPI_SCK_DIV,
   input  logic                                     I_SPI_TX_DONE
);

   if (TIMEOUT < 1) begin : g_timeout_check
      $error("spi_xfer_ctrl: TIMEOUT must be at least 1");
   end

   state_t     state;
   logic [7:0] byte_cnt;   // bytes still to go after the current one
   logic [1:0] mode_q;
   logic [3:0] cs_oh;
   logic       start_q;
   logic       tx_rise;

`ifdef SPI_XFER_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT + 1);
   logic [WDW-1:0] wdog;
`else
   assign O_ERR = 1'b0;
`endif

   spi_edge_det u_done_edge (
      .clk   (I_CLK),
      .rst_n (I_RST_N),
      .din   (I_SPI_TX_DONE),
      .rise  (tx_rise)
   );

   // Assemble the core control byte from the latched fields and the strobe
   always_comb begin
      O_SPI_MODE                     = 8'h00;
      O_SPI_MODE[MODE_LSB +: 2]      = mode_q;
      O_SPI_MODE[START_BIT]          = start_q;
      O_SPI_MODE[CS_LSB +: CS_BITS]  = cs_oh;
   end

   // Transfer sequencer; every output is set on the transition into the
   // state that owns it, so outputs line up with the state register
   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         state         <= ST_IDLE;
         byte_cnt      <= 8'h00;
         mode_q        <= 2'b00;
         cs_oh         <= 4'b0000;
         start_q       <= 1'b0;
         O_CMD_READY   <= 1'b0;
         O_TXB_READY   <= 1'b0;
         O_RXB_VALID   <= 1'b0;
         O_RXB_DATA    <= '0;
         O_BUSY        <= 1'b0;
         O_DONE        <= 1'b0;
         O_SPI_TX_DATA <= '0;
         O_SPI_SCK_DIV <= 8'h00;
`ifdef SPI_XFER_TIMEOUT_EN
         O_ERR         <= 1'b0;
         wdog          <= '0;
`endif
      end else begin
         start_q     <= 1'b0;
         O_RXB_VALID <= 1'b0;
         O_DONE      <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Ready rises one cycle after reset release and stays up here
               O_CMD_READY <= 1'b1;
               if (I_CMD_VALID && O_CMD_READY) begin
                  mode_q        <= I_CMD_MODE;
                  O_SPI_SCK_DIV <= I_CMD_DIV;
                  cs_oh         <= cs_onehot(32'(I_CMD_CS), N_CS);
                  byte_cnt      <= I_CMD_LEN;
                  O_CMD_READY   <= 1'b0;
                  O_BUSY        <= 1'b1;
                  O_TXB_READY   <= 1'b1;
`ifdef SPI_XFER_TIMEOUT_EN
                  O_ERR         <= 1'b0;
`endif
                  state         <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               // Chip select stays asserted however long the source stalls
               if (I_TXB_VALID) begin
                  O_SPI_TX_DATA <= I_TXB_DATA;
                  O_TXB_READY   <= 1'b0;
                  start_q       <= 1'b1;
                  state         <= ST_START;
               end
            end
            ST_START: begin
`ifdef SPI_XFER_TIMEOUT_EN
               wdog  <= '0;
`endif
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               // Receive data is captured with the done edge so it is
               // presented together with the CAPTURE state
               if (tx_rise) begin
                  O_RXB_DATA  <= I_SPI_RX_DATA;
                  O_RXB_VALID <= 1'b1;
                  state       <= ST_CAPTURE;
               end
`ifdef SPI_XFER_TIMEOUT_EN
               else if (wdog == WDW'(TIMEOUT - 1)) begin
                  cs_oh  <= 4'b0000;
                  O_ERR  <= 1'b1;
                  O_DONE <= 1'b1;
                  state  <= ST_FINISH;
               end else begin
                  wdog <= wdog + WDW'(1);
               end
`endif
            end
            ST_CAPTURE: begin
               if (byte_cnt == 8'h00) begin
                  cs_oh  <= 4'b0000;
                  O_DONE <= 1'b1;
                  state  <= ST_FINISH;
               end else begin
                  byte_cnt    <= byte_cnt - 8'd1;
                  O_TXB_READY <= 1'b1;
                  state       <= ST_FETCH;
               end
            end
            ST_FINISH: begin
               O_BUSY      <= 1'b0;
               O_CMD_READY <= 1'b1;
               state       <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_xfer_ctrl
//  Purpose  : Self-checking bench for spi_xfer_ctrl with a randomized SPI core
//             model, a TX byte source and a scoreboard monitor.
//             Define SPI_XFER_TIMEOUT_EN to include the watchdog scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_ctrl;

   localparam int N       = 8;
   localparam int N_CS    = 4;
   localparam int TIMEOUT = 16;

   logic       I_CLK, I_RST_N;
   logic       I_CMD_VALID, O_CMD_READY;
   logic [7:0] I_CMD_LEN;
   logic [1:0] I_CMD_CS;
   logic [1:0] I_CMD_MODE;
   logic [7:0] I_CMD_DIV;
   logic       I_TXB_VALID, O_TXB_READY;
   logic [7:0] I_TXB_DATA;
   logic       O_RXB_VALID;
   logic [7:0] O_RXB_DATA;
   logic       O_BUSY, O_DONE, O_ERR;
   logic [7:0] O_SPI_TX_DATA, I_SPI_RX_DATA, O_SPI_MODE, O_SPI_SCK_DIV;
   logic       I_SPI_TX_DONE;

   typedef struct {
      bit err;
      int nbytes;
   } done_exp_t;

   done_exp_t  exp_done[$];
   done_exp_t  de;
   logic [7:0] tx_q[$];
   logic [7:0] exp_rx[$];

   int n_chk = 0, n_err = 0, cyc = 0;
   int n_start = 0, n_rx = 0, done_cnt = 0;
   int rise_cyc = 0, last_start_cyc = 0;
   bit have_rise = 0, fast_ok = 0, core_silent = 0, exp_err = 0;
   logic [3:0] exp_cs_oh = 4'b0;
   logic [1:0] exp_mode = 2'b0;
   logic [7:0] exp_div = 8'h0;

   spi_xfer_ctrl #(.N(N), .N_CS(N_CS), .TIMEOUT(TIMEOUT)) dut (
      .I_CLK(I_CLK), .I_RST_N(I_RST_N),
      .I_CMD_VALID(I_CMD_VALID), .O_CMD_READY(O_CMD_READY),
      .I_CMD_LEN(I_CMD_LEN), .I_CMD_CS(I_CMD_CS), .I_CMD_MODE(I_CMD_MODE), .I_CMD_DIV(I_CMD_DIV),
      .I_TXB_VALID(I_TXB_VALID), .O_TXB_READY(O_TXB_READY), .I_TXB_DATA(I_TXB_DATA),
      .O_RXB_VALID(O_RXB_VALID), .O_RXB_DATA(O_RXB_DATA),
      .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_ERR(O_ERR),
      .O_SPI_TX_DATA(O_SPI_TX_DATA), .I_SPI_RX_DATA(I_SPI_RX_DATA),
      .O_SPI_MODE(O_SPI_MODE), .O_SPI_SCK_DIV(O_SPI_SCK_DIV),
      .I_SPI_TX_DONE(I_SPI_TX_DONE)
   );

   initial I_CLK = 1'b0;
   always #5 I_CLK = ~I_CLK;
   always @(posedge I_CLK) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {26'd0, O_CMD_READY, O_TXB_READY, O_RXB_VALID, O_RXB_DATA, O_BUSY, O_DONE,
              O_ERR, O_SPI_TX_DATA, O_SPI_MODE, O_SPI_SCK_DIV};
   endfunction

   // Scoreboard monitor: compares every DUT output event against expectations
   always @(negedge I_CLK) begin
      if (I_RST_N) begin
         if (O_DONE) begin
            done_cnt++;
            if (exp_done.size() == 0) begin
               chk("done_unexpected", O_DONE, 0);
            end else begin
               de = exp_done.pop_front();
               chk("done_err", O_ERR, de.err);
               if (de.err) begin
                  chk("timeout_latency", cyc - last_start_cyc, TIMEOUT + 1);
                  chk("timeout_rx_count", n_rx, 0);
               end else begin
                  chk("rx_count", n_rx, de.nbytes);
                  chk("start_count", n_start, de.nbytes);
               end
               exp_err = de.err;
            end
            chk("done_cs_off", O_SPI_MODE[7:4], 0);
         end else if (O_BUSY) begin
            chk("cs_onehot", O_SPI_MODE[7:4], exp_cs_oh);
            chk("busy_cmd_ready", O_CMD_READY, 0);
         end else begin
            chk("idle_cs_off", O_SPI_MODE[7:4], 0);
            chk("idle_txb_ready", O_TXB_READY, 0);
         end
         chk("err_flag", O_ERR, exp_err);
         if (O_SPI_MODE[3]) begin
            n_start++;
            last_start_cyc = cyc;
            chk("start_mode", O_SPI_MODE[1:0], exp_mode);
            chk("start_div", O_SPI_SCK_DIV, exp_div);
            if (have_rise && fast_ok) chk("done_to_start", cyc - rise_cyc, 3);
            have_rise = 0;
         end
         if (O_RXB_VALID) begin
            n_rx++;
            if (exp_rx.size() == 0) chk("rx_unexpected", O_RXB_VALID, 0);
            else chk("rx_data", O_RXB_DATA, exp_rx.pop_front());
         end
         if (O_CMD_READY && I_CMD_VALID) begin
            n_start   = 0;
            n_rx      = 0;
            have_rise = 0;
            exp_err   = 0;
         end
      end
   end

   // TX byte source: presents the queue head, pops after each handshake
   initial begin
      bit hs;
      I_TXB_VALID = 1'b0;
      I_TXB_DATA  = 8'h00;
      forever begin
         @(negedge I_CLK);
         hs = I_TXB_VALID && O_TXB_READY && I_RST_N;
         @(posedge I_CLK);
         #1;
         if (hs && tx_q.size() > 0) void'(tx_q.pop_front());
         I_TXB_VALID = (tx_q.size() > 0);
         I_TXB_DATA  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
      end
   end

   // SPI core model: returns the inverted TX byte after a random latency,
   // sometimes keeping the previous done level high into the next byte
   initial begin
      logic [7:0] txv;
      I_SPI_TX_DONE = 1'b0;
      I_SPI_RX_DATA = 8'h00;
      forever begin
         @(negedge I_CLK);
         if (I_RST_N && O_SPI_MODE[3] && !core_silent) begin
            txv = O_SPI_TX_DATA;
            if (I_SPI_TX_DONE && $urandom_range(0, 1) == 1)
               repeat ($urandom_range(1, 3)) @(negedge I_CLK);
            I_SPI_TX_DONE = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge I_CLK);
            if (I_RST_N && !core_silent) begin
               I_SPI_RX_DATA = ~txv;
               I_SPI_TX_DONE = 1'b1;
               rise_cyc      = cyc;
               have_rise     = 1;
               fast_ok       = (tx_q.size() > 0);
            end
         end
      end
   end

   task automatic issue_cmd(input logic [7:0] len, input int cs, input logic [1:0] mode,
                            input logic [7:0] div, input bit junk);
      bit ok = 0;
      exp_cs_oh = 4'b0001 << cs;
      exp_mode  = mode;
      exp_div   = div;
      @(posedge I_CLK);
      #1;
      I_CMD_VALID = 1'b1;
      I_CMD_LEN   = len;
      I_CMD_CS    = 2'(cs);
      I_CMD_MODE  = mode;
      I_CMD_DIV   = div;
      for (int k = 0; k < 100; k++) begin
         @(negedge I_CLK);
         if (O_CMD_READY) begin
            ok = 1;
            break;
         end
      end
      chk("cmd_accept", ok, 1);
      @(posedge I_CLK);
      #1;
      if (junk) begin
         // keep a conflicting command pending while busy; it must be ignored
         I_CMD_CS   = ~I_CMD_CS;
         I_CMD_MODE = ~mode;
         I_CMD_DIV  = ~div;
         I_CMD_LEN  = 8'h00;
      end else begin
         I_CMD_VALID = 1'b0;
      end
   endtask

   task automatic wait_done(input int d0, input string name);
      bit ok = 0;
      for (int k = 0; k < 20000; k++) begin
         @(negedge I_CLK);
         #1;
         if (done_cnt > d0) begin
            ok = 1;
            break;
         end
      end
      I_CMD_VALID = 1'b0;
      chk(name, ok, 1);
   endtask

   task automatic run_cmd(input logic [7:0] len, input int cs, input logic [1:0] mode,
                          input logic [7:0] div, input int base, input bit starve, input bit junk);
      logic [7:0] held[$];
      logic [7:0] b;
      int nb = int'(len) + 1;
      int d0 = done_cnt;
      bit ok = 0;
      for (int i = 0; i < nb; i++) begin
         b = (base < 0) ? 8'($urandom) : 8'(base + i);
         if (starve && i > 0) held.push_back(b);
         else tx_q.push_back(b);
         exp_rx.push_back(~b);
      end
      exp_done.push_back('{err: 1'b0, nbytes: nb});
      issue_cmd(len, cs, mode, div, junk);
      if (starve) begin
         for (int k = 0; k < 2000; k++) begin
            @(negedge I_CLK);
            #1;
            if (n_rx >= 1) begin
               ok = 1;
               break;
            end
         end
         chk("starve_first_byte", ok, 1);
         repeat (50) @(negedge I_CLK);
         chk("starve_no_start", n_start, 1);
         chk("starve_txb_ready", O_TXB_READY, 1);
         chk("starve_cs_held", O_SPI_MODE[7:4], exp_cs_oh);
         while (held.size() > 0) tx_q.push_back(held.pop_front());
      end
      wait_done(d0, "done_seen");
   endtask

   initial begin
      bit ok;
      int d0;
      I_RST_N = 1'b1;
      I_CMD_VALID = 1'b0; I_CMD_LEN = 8'h00; I_CMD_CS = 2'b00;
      I_CMD_MODE = 2'b00; I_CMD_DIV = 8'h00;
      #2 I_RST_N = 1'b0;
      #10;
      chk("reset_outputs", all_outs(), 64'd0);
      @(negedge I_CLK);
      #2 I_RST_N = 1'b1;
      @(negedge I_CLK);
      chk("reset_release_ready", O_CMD_READY, 1);

      // single byte: CS=2, MODE=3, DIV=8, TX AA -> RX 55
      run_cmd(8'd0, 2, 2'd3, 8'd8, 'hAA, 0, 0);
      // burst 10..13 with a conflicting command held during the burst
      run_cmd(8'd3, 1, 2'd1, 8'd4, 'h10, 0, 1);
      // randomized commands
      for (int t = 0; t < 5; t++)
         run_cmd(8'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 2'($urandom),
                 8'($urandom), -1, 0, 0);
      // TX starvation after the first byte
      run_cmd(8'd3, 3, 2'd0, 8'd2, -1, 1, 0);
      // 256-byte transfer
      run_cmd(8'hFF, 0, 2'd2, 8'd1, -1, 0, 0);

      // reset during WAIT of byte 2
      for (int i = 0; i < 4; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         tx_q.push_back(b);
         exp_rx.push_back(~b);
      end
      exp_done.push_back('{err: 1'b0, nbytes: 4});
      d0 = done_cnt;
      issue_cmd(8'd3, 1, 2'd2, 8'd6, 0);
      ok = 0;
      for (int k = 0; k < 500; k++) begin
         @(negedge I_CLK);
         #1;
         if (n_rx >= 1) begin
            ok = 1;
            break;
         end
      end
      chk("rst_test_byte1", ok, 1);
      core_silent = 1;
      ok = 0;
      for (int k = 0; k < 500; k++) begin
         @(negedge I_CLK);
         #1;
         if (n_start >= 2) begin
            ok = 1;
            break;
         end
      end
      chk("rst_test_start2", ok, 1);
      @(negedge I_CLK);
      #2 I_RST_N = 1'b0;
      #1;
      chk("rst_async_outputs", all_outs(), 64'd0);
      tx_q.delete();
      exp_rx.delete();
      exp_done.delete();
      exp_err = 0;
      repeat (3) @(negedge I_CLK);
      chk("rst_held_outputs", all_outs(), 64'd0);
      #2 I_RST_N = 1'b1;
      core_silent = 0;
      @(negedge I_CLK);
      chk("rst_post_ready", O_CMD_READY, 1);
      chk("rst_post_busy", O_BUSY, 0);
      repeat (5) @(negedge I_CLK);
      chk("rst_no_done", done_cnt, d0);

`ifdef SPI_XFER_TIMEOUT_EN
      // core never answers: watchdog aborts and flags the error
      core_silent = 1;
      tx_q.push_back(8'h3C);
      exp_done.push_back('{err: 1'b1, nbytes: 1});
      d0 = done_cnt;
      issue_cmd(8'd0, 3, 2'd1, 8'd5, 0);
      wait_done(d0, "timeout_done_seen");
      repeat (4) @(negedge I_CLK);
      chk("timeout_err_sticky", O_ERR, 1);
      core_silent = 0;
      // the next accepted command clears the flag
      run_cmd(8'd1, 0, 2'd0, 8'd3, -1, 0, 0);
      chk("timeout_err_cleared", O_ERR, 0);
`else
      chk("err_tied_low", O_ERR, 0);
`endif

      // one more random burst after everything else
      run_cmd(8'($urandom_range(4, 12)), int'($urandom_range(0, 3)), 2'($urandom),
              8'($urandom), -1, 0, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
`default_nettype wire
